// File: rtl/ram_bist_controller_pkg.sv
// Shared types and defaults for the RAM march-test sequencer.
// State encodings, default widths and a small state-classification helper.
package ram_bist_controller_pkg;

  localparam int AW_DEF = 8;
  localparam int DW_DEF = 8;
  localparam int CW_DEF = 16;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_W0   = 3'd1,
    ST_R1   = 3'd2,
    ST_C1   = 3'd3,
    ST_W1   = 3'd4,
    ST_R2   = 3'd5,
    ST_C2   = 3'd6,
    ST_DONE = 3'd7
  } state_t;

  function automatic logic is_busy_state(input state_t s);
    return (s != ST_IDLE) && (s != ST_DONE);
  endfunction

endpackage

// File: rtl/ram_bist_controller_addr_gen.sv
// Address counter for the march sequencer: loadable up/down counter whose
// terminal-count flag follows the current direction (all-ones up, zero down).
module ram_bist_controller_addr_gen #(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [AW-1:0] load_val,
  input  logic          en,
  input  logic          up,
  output logic [AW-1:0] count,
  output logic [AW-1:0] count_nxt,
  output logic          tc
);

  logic [AW-1:0] count_r;
  logic [AW-1:0] count_nxt_s;

  // next count: load wins over enable
  always_comb begin
    count_nxt_s = count_r;
    if (load) begin
      count_nxt_s = load_val;
    end else if (en) begin
      if (up) begin
        count_nxt_s = count_r + {{(AW-1){1'b0}}, 1'b1};
      end else begin
        count_nxt_s = count_r - {{(AW-1){1'b0}}, 1'b1};
      end
    end else begin
      count_nxt_s = count_r;
    end
  end

  // counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= {AW{1'b0}};
    end else begin
      count_r <= count_nxt_s;
    end
  end

  assign count     = count_r;
  assign count_nxt = count_nxt_s;
  assign tc        = up ? (count_r == {AW{1'b1}}) : (count_r == {AW{1'b0}});

endmodule

// File: rtl/ram_bist_controller.sv
// March-test BIST sequencer driving a single-port RAM: write P(a), then
// read/check/write ~P(a) ascending, then read/check ~P(a) descending.
module ram_bist_controller
  import ram_bist_controller_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF,
  parameter int CW = CW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] seed,
  output logic          mem_wr,
  output logic          mem_rd,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_din,
  input  logic [DW-1:0] mem_dout,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [CW-1:0] err_count,
  output logic [AW-1:0] first_err_addr,
  output logic [DW-1:0] first_err_data
);

  state_t        state_r, state_nxt_s;
  logic [DW-1:0] seed_r, seed_now_s;
  logic [AW-1:0] cnt_s, cnt_nxt_s;
  logic          tc_s, ld_s, en_s, up_s;
  logic          cmp_s, mismatch_s, accept_s;
  logic [DW-1:0] exp_s;
  logic [CW-1:0] err_nxt_s;

  logic          mem_wr_r, mem_rd_r, busy_r, done_r, pass_r;
  logic [DW-1:0] mem_din_r, first_err_data_r;
  logic [CW-1:0] err_count_r;
  logic [AW-1:0] first_err_addr_r;

  function automatic logic [DW-1:0] pattern(input logic [AW-1:0] a, input logic [DW-1:0] s);
    return DW'(a) ^ s;
  endfunction

  ram_bist_controller_addr_gen #(.AW(AW)) u_addr_gen (
    .clk       (clk),
    .rst       (rst),
    .load      (ld_s),
    .load_val  ({AW{1'b0}}),
    .en        (en_s),
    .up        (up_s),
    .count     (cnt_s),
    .count_nxt (cnt_nxt_s),
    .tc        (tc_s)
  );

  // The first W0 write is issued on the accepting edge, before seed_r is loaded.
  assign seed_now_s = (state_r == ST_IDLE) ? seed : seed_r;
  assign accept_s   = (state_r == ST_IDLE) && start;

  // march sequencing: next state, counter control and compare selection
  always_comb begin
    state_nxt_s = state_r;
    ld_s        = 1'b0;
    en_s        = 1'b0;
    up_s        = 1'b1;
    cmp_s       = 1'b0;
    exp_s       = {DW{1'b0}};
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_nxt_s = ST_W0;
          ld_s        = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_W0: begin
        if (tc_s) begin
          state_nxt_s = ST_R1;
          ld_s        = 1'b1;
        end else begin
          en_s = 1'b1;
        end
      end
      ST_R1: state_nxt_s = ST_C1;
      ST_C1: begin
        state_nxt_s = ST_W1;
        cmp_s       = 1'b1;
        exp_s       = pattern(cnt_s, seed_r);
      end
      ST_W1: begin
        // phase 2 starts at the terminal address, so the counter just holds
        if (tc_s) begin
          state_nxt_s = ST_R2;
        end else begin
          state_nxt_s = ST_R1;
          en_s        = 1'b1;
        end
      end
      ST_R2: begin
        up_s        = 1'b0;
        state_nxt_s = ST_C2;
      end
      ST_C2: begin
        up_s  = 1'b0;
        cmp_s = 1'b1;
        exp_s = ~pattern(cnt_s, seed_r);
        if (tc_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_R2;
          en_s        = 1'b1;
        end
      end
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // saturating error count for this cycle's compare
  always_comb begin
    mismatch_s = cmp_s && (mem_dout != exp_s);
    if (mismatch_s && (err_count_r != {CW{1'b1}})) begin
      err_nxt_s = err_count_r + {{(CW-1){1'b0}}, 1'b1};
    end else begin
      err_nxt_s = err_count_r;
    end
  end

  // state register and registered outputs, aligned with the state they describe
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r          <= ST_IDLE;
      seed_r           <= {DW{1'b0}};
      mem_wr_r         <= 1'b0;
      mem_rd_r         <= 1'b0;
      mem_din_r        <= {DW{1'b0}};
      busy_r           <= 1'b0;
      done_r           <= 1'b0;
      pass_r           <= 1'b0;
      err_count_r      <= {CW{1'b0}};
      first_err_addr_r <= {AW{1'b0}};
      first_err_data_r <= {DW{1'b0}};
    end else begin
      state_r  <= state_nxt_s;
      mem_wr_r <= (state_nxt_s == ST_W0) || (state_nxt_s == ST_W1);
      mem_rd_r <= (state_nxt_s == ST_R1) || (state_nxt_s == ST_R2);
      busy_r   <= is_busy_state(state_nxt_s);
      done_r   <= (state_nxt_s == ST_DONE);
      if (state_nxt_s == ST_W0) begin
        mem_din_r <= pattern(cnt_nxt_s, seed_now_s);
      end else if (state_nxt_s == ST_W1) begin
        mem_din_r <= ~pattern(cnt_nxt_s, seed_r);
      end else begin
        mem_din_r <= {DW{1'b0}};
      end
      if (accept_s) begin
        seed_r           <= seed;
        err_count_r      <= {CW{1'b0}};
        first_err_addr_r <= {AW{1'b0}};
        first_err_data_r <= {DW{1'b0}};
        pass_r           <= 1'b0;
      end else begin
        err_count_r <= err_nxt_s;
        if (mismatch_s && (err_count_r == {CW{1'b0}})) begin
          first_err_addr_r <= cnt_s;
          first_err_data_r <= mem_dout;
        end else begin
          first_err_addr_r <= first_err_addr_r;
          first_err_data_r <= first_err_data_r;
        end
        if (state_nxt_s == ST_DONE) begin
          pass_r <= (err_nxt_s == {CW{1'b0}});
        end else begin
          pass_r <= pass_r;
        end
      end
    end
  end

  assign mem_wr         = mem_wr_r;
  assign mem_rd         = mem_rd_r;
  assign mem_addr       = cnt_s;
  assign mem_din        = mem_din_r;
  assign busy           = busy_r;
  assign done           = done_r;
  assign pass           = pass_r;
  assign err_count      = err_count_r;
  assign first_err_addr = first_err_addr_r;
  assign first_err_data = first_err_data_r;

endmodule

// File: tb/tb_ram_bist_controller.sv
// Bench for ram_bist_controller: behavioural RAM with optional stuck-at-0 bit,
// per-cycle bus-sequence model plus a march-result model.
module tb_ram_bist_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  seed;
  logic        mem_wr, mem_rd, busy, done, pass;
  logic [7:0]  mem_addr, mem_din, first_err_addr, first_err_data;
  logic [7:0]  mem_dout = 8'h00;
  logic [15:0] err_count;

  logic [7:0]  ram [0:255];
  logic        fault_en;
  logic [7:0]  fault_addr;

  typedef struct {
    bit         wr;
    bit         rd;
    bit         busy;
    bit         done;
    bit         chk_addr;
    logic [7:0] addr;
    logic [7:0] din;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int overlap = 0;

  always #5 clk = ~clk;

  ram_bist_controller #(.AW(8), .DW(8), .CW(16)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .seed           (seed),
    .mem_wr         (mem_wr),
    .mem_rd         (mem_rd),
    .mem_addr       (mem_addr),
    .mem_din        (mem_din),
    .mem_dout       (mem_dout),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .err_count      (err_count),
    .first_err_addr (first_err_addr),
    .first_err_data (first_err_data)
  );

  // single-port RAM, read data registered one cycle after mem_rd
  always @(posedge clk) begin
    if (mem_wr) ram[mem_addr] <= (fault_en && mem_addr == fault_addr) ? (mem_din & 8'hFE) : mem_din;
    if (mem_rd) mem_dout <= ram[mem_addr];
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  function automatic logic [7:0] pat(input logic [7:0] a, input logic [7:0] s);
    return a ^ s;
  endfunction

  function automatic exp_t mk(input bit wr, input bit rd, input bit bz, input bit dn,
                              input bit ca, input logic [7:0] a, input logic [7:0] d);
    exp_t e;
    e.wr = wr; e.rd = rd; e.busy = bz; e.done = dn; e.chk_addr = ca; e.addr = a; e.din = d;
    return e;
  endfunction

  // expected bus activity, one entry per cycle following the start edge
  task automatic build_queue(input logic [7:0] s);
    logic [7:0] a;
    q.delete();
    for (int i = 0; i < 256; i++) begin
      a = 8'(i);
      q.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, a, pat(a, s)));
    end
    for (int i = 0; i < 256; i++) begin
      a = 8'(i);
      q.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, a, 8'h00));
      q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, a, 8'h00));
      q.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, a, ~pat(a, s)));
    end
    for (int i = 255; i >= 0; i--) begin
      a = 8'(i);
      q.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, a, 8'h00));
      q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, a, 8'h00));
    end
    q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00));
    q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00));
  endtask

  // march outcome computed directly on an array with the same fault
  task automatic predict(input logic [7:0] s, input logic fen, input logic [7:0] fa,
                         output int e, output logic [7:0] fea, output logic [7:0] fed);
    logic [7:0] m [0:255];
    logic [7:0] a, v;
    e = 0; fea = 8'h00; fed = 8'h00;
    for (int i = 0; i < 256; i++) begin
      a = 8'(i); v = pat(a, s);
      m[i] = (fen && a == fa) ? (v & 8'hFE) : v;
    end
    for (int i = 0; i < 256; i++) begin
      a = 8'(i); v = pat(a, s);
      if (m[i] != v) begin
        if (e == 0) begin fea = a; fed = m[i]; end
        e++;
      end
      m[i] = (fen && a == fa) ? (~v & 8'hFE) : ~v;
    end
    for (int i = 255; i >= 0; i--) begin
      a = 8'(i); v = ~pat(a, s);
      if (m[i] != v) begin
        if (e == 0) begin fea = a; fed = m[i]; end
        e++;
      end
    end
  endtask

  // per-cycle compare against the expected bus sequence
  always @(negedge clk) begin
    exp_t e;
    if (mem_wr && mem_rd) overlap++;
    if (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      if (mem_wr !== e.wr || mem_rd !== e.rd || busy !== e.busy || done !== e.done ||
          (e.chk_addr && mem_addr !== e.addr) || (e.wr && mem_din !== e.din)) begin
        errors++;
        $display("FAIL cycle got wr=%b rd=%b busy=%b done=%b addr=%h din=%h want wr=%b rd=%b busy=%b done=%b addr=%h din=%h",
                 mem_wr, mem_rd, busy, done, mem_addr, mem_din,
                 e.wr, e.rd, e.busy, e.done, e.addr, e.din);
      end
    end
  end

  task automatic launch(input logic [7:0] s);
    @(negedge clk);
    seed  = s;
    start = 1'b1;
    @(posedge clk);
    build_queue(s);
    #1 start = 1'b0;
  endtask

  // start edge is edge 1; returns the edge after which done was first seen
  task automatic run(input logic [7:0] s, input int extra_at, output int done_edge, output int pulses);
    launch(s);
    done_edge = 0;
    pulses    = 0;
    for (int k = 2; k <= 1545; k++) begin
      @(negedge clk);
      start = (k == extra_at);
      @(posedge clk);
      #1;
      if (done) begin
        pulses++;
        if (done_edge == 0) done_edge = k;
      end
    end
    start = 1'b0;
    check("queue_drained", q.size(), 0);
  endtask

  task automatic check_result(input string tag, input logic [7:0] s, input int done_edge, input int pulses);
    int         pe;
    logic [7:0] pa, pd;
    predict(s, fault_en, fault_addr, pe, pa, pd);
    check({tag, "_done_edge"}, done_edge, 1537);
    check({tag, "_done_pulses"}, pulses, 1);
    check({tag, "_err_count"}, err_count, pe);
    check({tag, "_pass"}, pass, (pe == 0));
    if (pe != 0) begin
      check({tag, "_first_addr"}, first_err_addr, pa);
      check({tag, "_first_data"}, first_err_data, pd);
    end
    check({tag, "_no_overlap"}, overlap, 0);
  endtask

  initial begin
    int         de, np, pe;
    logic [7:0] pa, pd;
    bit         found;
    for (int i = 0; i < 256; i++) ram[i] = 8'h00;
    rst = 1'b1; start = 1'b0; seed = 8'h00; fault_en = 1'b0; fault_addr = 8'h00;

    // 1: reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_wr_rd", {mem_wr, mem_rd}, 2'b00);
    check("rst_busy_done_pass", {busy, done, pass}, 3'b000);
    check("rst_addr_din", {mem_addr, mem_din}, 16'h0000);
    check("rst_err", {err_count, first_err_addr, first_err_data}, 32'h0);
    rst = 1'b0;

    // 2: fault-free run, seed A5
    run(8'hA5, 0, de, np);
    check_result("clean", 8'hA5, de, np);
    check("clean_pass_lit", pass, 1'b1);
    check("clean_err_lit", err_count, 16'd0);

    // 3: bit0 stuck-at-0 at 3C
    fault_en = 1'b1; fault_addr = 8'h3C;
    predict(8'hA5, 1'b1, 8'h3C, pe, pa, pd);
    check("model_err_lit", pe, 1);
    check("model_addr_lit", pa, 8'h3C);
    check("model_data_lit", pd, 8'h98);
    run(8'hA5, 0, de, np);
    check_result("fault", 8'hA5, de, np);
    check("fault_err_lit", err_count, 16'd1);
    check("fault_addr_lit", first_err_addr, 8'h3C);
    check("fault_data_lit", first_err_data, 8'h98);
    check("fault_pass_lit", pass, 1'b0);
    repeat (3) @(posedge clk);
    #1 check("pass_held", pass, 1'b0);

    // 6: fault removed, seed 00 clears previous failure
    fault_en = 1'b0;
    run(8'h00, 0, de, np);
    check_result("rerun", 8'h00, de, np);
    check("rerun_err_lit", err_count, 16'd0);

    // 4: start pulse mid-run is ignored
    run(8'h5A, 100, de, np);
    check_result("restart_ignored", 8'h5A, de, np);

    // 5: reset during phase 1 at address 10
    launch(8'h33);
    found = 1'b0;
    for (int k = 0; k < 2000 && !found; k++) begin
      @(posedge clk);
      #1;
      if (mem_rd && mem_addr == 8'h10) found = 1'b1;
    end
    check("reach_addr10", found, 1'b1);
    q.delete();
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_busy", busy, 1'b0);
    check("midrst_wr_rd", {mem_wr, mem_rd}, 2'b00);
    check("midrst_done", done, 1'b0);
    check("midrst_addr", mem_addr, 8'h00);
    rst = 1'b0;
    run(8'h33, 0, de, np);
    check_result("after_rst", 8'h33, de, np);
    check("after_rst_pass_lit", pass, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
